// File: rtl/aplic_msi_pkg.sv
// Shared types and constants for the APLIC MSI-mode delivery scheduler.
package aplic_msi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int EIID_W         = 11;
  localparam int MSI_PAGE_SHIFT = 12;

endpackage

// File: rtl/aplic_rr_picker.sv
// Rotating find-first: returns the first set bit at or after start_i,
// wrapping from NR_SRC-1 back to 1. Bit 0 is never selected.
module aplic_rr_picker #(
  parameter int NR_SRC = 256,
  parameter int IDX_W  = $clog2(NR_SRC)
) (
  input  logic [NR_SRC-1:0] vec_i,
  input  logic [IDX_W-1:0]  start_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NR_SRC - 1);

  logic [IDX_W:0] pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = NR_SRC - 2; k >= 0; k--) begin
      pos = {1'b0, start_i} + (IDX_W+1)'(k);
      if (pos > LAST) pos = pos - LAST;
      if (vec_i[pos[IDX_W-1:0]] && (pos[IDX_W-1:0] != '0)) begin
        found_o = 1'b1;
        idx_o   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/aplic_msi_scheduler.sv
// MSI-mode APLIC domain sequencer: picks a pending+enabled source round-robin,
// reads its target register, issues one MSI write and clears the pending bit.
module aplic_msi_scheduler
  import aplic_msi_pkg::*;
#(
  parameter int NR_SRC   = 256,
  parameter int NR_HARTS = 5,
  parameter int XLEN     = 64,
  parameter int IDX_W    = $clog2(NR_SRC),
  parameter int HART_W   = $clog2(NR_HARTS)
) (
  input  logic              i_clk,
  input  logic              ni_rst,
  input  logic              i_domain_ie,
  input  logic [NR_SRC-1:0] i_pending,
  input  logic [NR_SRC-1:0] i_enabled,
  output logic [IDX_W-1:0]  o_tgt_idx,
  input  logic [HART_W-1:0] i_tgt_hart,
  input  logic [EIID_W-1:0] i_tgt_eiid,
  input  logic [XLEN-1:0]   i_msi_base,
  output logic              o_msi_valid,
  input  logic              i_msi_ready,
  output logic [XLEN-1:0]   o_msi_addr,
  output logic [31:0]       o_msi_data,
  output logic              o_clr_valid,
  output logic [IDX_W-1:0]  o_clr_idx,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SRC - 1);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? IDX_W'(1) : i + IDX_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [EIID_W-1:0] eiid_q, eiid_d;
  logic [XLEN-1:0]   addr_q, addr_d;

  logic [NR_SRC-1:0] cand;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              sel_live;
  logic              msi_valid;
  logic              clr_valid;

  assign cand     = i_pending & i_enabled & {NR_SRC{i_domain_ie}};
  assign sel_live = i_pending[sel_q] & i_enabled[sel_q];

  aplic_rr_picker #(
    .NR_SRC (NR_SRC),
    .IDX_W  (IDX_W)
  ) u_picker (
    .vec_i   (cand),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // MSI port: valid rises in SEND and stays up until the cycle valid&ready is
  // seen; addr/data come from registers, so they cannot move while waiting.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    eiid_d    = eiid_q;
    addr_d    = addr_q;
    msi_valid = 1'b0;
    clr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = RD;
        end
      end
      RD: begin
        if (!sel_live) begin
          state_d = IDLE;
        end else if (i_tgt_eiid == '0) begin
          clr_valid = 1'b1;
          rr_ptr_d  = next_idx(sel_q);
          state_d   = IDLE;
        end else begin
          eiid_d  = i_tgt_eiid;
          addr_d  = i_msi_base + (XLEN'(i_tgt_hart) << MSI_PAGE_SHIFT);
          state_d = SEND;
        end
      end
      SEND: begin
        msi_valid = 1'b1;
        if (i_msi_ready) begin
          clr_valid = 1'b1;
          rr_ptr_d  = next_idx(sel_q);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(1);
      sel_q    <= '0;
      eiid_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      eiid_q   <= eiid_d;
      addr_q   <= addr_d;
    end
  end

  assign o_tgt_idx   = sel_q;
  assign o_clr_idx   = sel_q;
  assign o_clr_valid = clr_valid;
  assign o_msi_valid = msi_valid;
  assign o_msi_addr  = addr_q;
  assign o_msi_data  = {{(32-EIID_W){1'b0}}, eiid_q};
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_aplic_msi_scheduler.sv
// Self-checking bench for aplic_msi_scheduler: the bench owns the pending
// register and a target-register table, and scores every clear/MSI write.
module tb_aplic_msi_scheduler;
  import aplic_msi_pkg::*;

  localparam int NR_SRC = 256;
  localparam int XLEN   = 64;
  localparam int EW     = 1 + 8 + XLEN + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               ie;
  logic [NR_SRC-1:0]  pend, en, set_req, drop_req;
  logic [7:0]         tgt_idx;
  logic [2:0]         tgt_hart;
  logic [10:0]        tgt_eiid;
  logic [63:0]        base;
  logic               msi_valid, ready;
  logic [63:0]        msi_addr;
  logic [31:0]        msi_data;
  logic               clr_valid;
  logic [7:0]         clr_idx;
  logic               busy;
  logic [1:0]         dbg_state;

  logic [2:0]  hart_tab [NR_SRC];
  logic [10:0] eiid_tab [NR_SRC];

  assign tgt_hart = hart_tab[tgt_idx];
  assign tgt_eiid = eiid_tab[tgt_idx];

  aplic_msi_scheduler #(.NR_SRC(NR_SRC), .NR_HARTS(5), .XLEN(XLEN)) dut (
    .i_clk       (clk),
    .ni_rst      (rst_n),
    .i_domain_ie (ie),
    .i_pending   (pend),
    .i_enabled   (en),
    .o_tgt_idx   (tgt_idx),
    .i_tgt_hart  (tgt_hart),
    .i_tgt_eiid  (tgt_eiid),
    .i_msi_base  (base),
    .o_msi_valid (msi_valid),
    .i_msi_ready (ready),
    .o_msi_addr  (msi_addr),
    .o_msi_data  (msi_data),
    .o_clr_valid (clr_valid),
    .o_clr_idx   (clr_idx),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // Pending register owner: sets/drops from stimulus, clear applied on the edge.
  always @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else begin
      pend <= (pend | set_req) & ~drop_req;
      if (clr_valid) pend[clr_idx] <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int clr_count = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  function automatic logic [NR_SRC-1:0] bit_of(input int i);
    logic [NR_SRC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic expect_msi(input int idx);
    logic [63:0] a;
    a = base + (64'(hart_tab[idx]) << 12);
    exp_q.push_back({1'b1, 8'(idx), a, 21'b0, eiid_tab[idx]});
  endtask

  task automatic expect_clr_only(input int idx);
    exp_q.push_back({1'b0, 8'(idx), 64'b0, 32'b0});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (msi_valid) check("clr_on_handshake", clr_valid, ready);
      if (clr_valid) begin
        clr_count++;
        check("clr_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("clr_idx", clr_idx, mon_e[103:96]);
          check("clr_with_valid", msi_valid, mon_e[104]);
          if (mon_e[104]) begin
            check("msi_addr", msi_addr, mon_e[95:32]);
            check("msi_data", msi_data, mon_e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [NR_SRC-1:0] m);
    set_req = m;
    tick();
    set_req = '0;
  endtask

  task automatic wait_drain(input int max_cycles, input bit rnd_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      tick();
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("drain_in_time", n < max_cycles, 1'b1);
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!msi_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("valid_in_time", msi_valid, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ea;
    int snap;
    int idx;
    ie = 1'b0; set_req = '0; drop_req = '0; en = '0; base = '0; ready = 1'b0;
    for (int i = 0; i < NR_SRC; i++) begin
      hart_tab[i] = '0;
      eiid_tab[i] = '0;
    end
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    check("rst_valid", msi_valid, 1'b0);
    check("rst_clr", clr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    check("rst_tgt_idx", tgt_idx, 8'd0);
    check("rst_addr", msi_addr, 64'd0);
    check("rst_data", msi_data, 32'd0);
    tick();
    rst_n = 1'b1; ie = 1'b1; ready = 1'b1;

    // Single source: 5 -> hart 2, EIID 0x23
    base = 64'h2800_0000;
    hart_tab[5] = 3'd2; eiid_tab[5] = 11'h23;
    en = bit_of(5);
    expect_msi(5);
    raise(bit_of(5));
    @(negedge clk);
    check("t1_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("t1_rd_state", dbg_state, RD);
    check("t1_rd_tgt_idx", tgt_idx, 8'd5);
    check("t1_rd_valid", msi_valid, 1'b0);
    @(negedge clk);
    check("t1_valid", msi_valid, 1'b1);
    check("t1_addr", msi_addr, 64'h2800_2000);
    check("t1_data", msi_data, 32'h23);
    check("t1_clr", clr_valid, 1'b1);
    @(negedge clk);
    check("t1_back_idle", busy, 1'b0);
    wait_drain(20, 1'b0);

    // Round-robin from rr_ptr = 1
    tick(); rst_n = 1'b0; tick(); rst_n = 1'b1;
    hart_tab[3] = 3'd0; eiid_tab[3] = 11'h31;
    hart_tab[7] = 3'd1; eiid_tab[7] = 11'h71;
    hart_tab[200] = 3'd4; eiid_tab[200] = 11'h200;
    en = bit_of(3) | bit_of(7) | bit_of(200);
    expect_msi(3); expect_msi(7); expect_msi(200);
    raise(bit_of(3) | bit_of(7) | bit_of(200));
    wait_drain(50, 1'b0);
    expect_msi(3); expect_msi(7);
    raise(bit_of(3) | bit_of(7));
    wait_drain(50, 1'b0);

    // Backpressure, pending dropped mid-SEND
    hart_tab[40] = 3'd4; eiid_tab[40] = 11'h7ff;
    en = en | bit_of(40);
    ready = 1'b0;
    ea = base + (64'd4 << 12);
    snap = clr_count;
    expect_msi(40);
    raise(bit_of(40));
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      check("t3_valid_hold", msi_valid, 1'b1);
      check("t3_addr_hold", msi_addr, ea);
      check("t3_data_hold", msi_data, 32'h7ff);
      check("t3_no_clr", clr_valid, 1'b0);
      tick();
      drop_req = (i == 3) ? bit_of(40) : '0;
      if (i == 9) ready = 1'b1;
      @(negedge clk);
    end
    wait_drain(20, 1'b0);
    check("t3_one_clear", clr_count - snap, 1);

    // Drop in RD: rr_ptr stays at 41, so 50 wins over 20
    hart_tab[9] = 3'd1; eiid_tab[9] = 11'd5;
    hart_tab[20] = 3'd0; eiid_tab[20] = 11'h14;
    hart_tab[50] = 3'd3; eiid_tab[50] = 11'h32;
    en = en | bit_of(9) | bit_of(20) | bit_of(50);
    snap = clr_count;
    raise(bit_of(9));
    drop_req = bit_of(9);
    @(negedge clk);
    check("t4_idle_busy", busy, 1'b0);
    tick();
    drop_req = '0;
    @(negedge clk);
    check("t4_rd_state", dbg_state, RD);
    check("t4_rd_clr", clr_valid, 1'b0);
    @(negedge clk);
    check("t4_idle_after", busy, 1'b0);
    check("t4_no_valid", msi_valid, 1'b0);
    check("t4_no_clear", clr_count - snap, 0);
    expect_msi(50); expect_msi(20);
    raise(bit_of(20) | bit_of(50));
    wait_drain(50, 1'b0);

    // EIID 0 on source 12: clear only, then 13 served before 11
    hart_tab[12] = 3'd2; eiid_tab[12] = 11'd0;
    hart_tab[13] = 3'd1; eiid_tab[13] = 11'h13;
    hart_tab[11] = 3'd0; eiid_tab[11] = 11'h11;
    en = en | bit_of(11) | bit_of(12) | bit_of(13);
    expect_clr_only(12);
    raise(bit_of(12));
    @(negedge clk);
    @(negedge clk);
    check("t5_rd_clr", clr_valid, 1'b1);
    check("t5_rd_clr_idx", clr_idx, 8'd12);
    check("t5_rd_valid", msi_valid, 1'b0);
    @(negedge clk);
    check("t5_idle_after", busy, 1'b0);
    wait_drain(20, 1'b0);
    expect_msi(13); expect_msi(11);
    raise(bit_of(11) | bit_of(13));
    wait_drain(50, 1'b0);

    // Reset during SEND, then rr_ptr = 1 means 2 beats 150
    hart_tab[100] = 3'd1; eiid_tab[100] = 11'h64;
    en = en | bit_of(100);
    ready = 1'b0;
    raise(bit_of(100));
    wait_valid(10);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", msi_valid, 1'b0);
    check("t6_busy_after_rst", busy, 1'b0);
    check("t6_clr_after_rst", clr_valid, 1'b0);
    ready = 1'b1;
    hart_tab[2] = 3'd0; eiid_tab[2] = 11'h2;
    hart_tab[150] = 3'd2; eiid_tab[150] = 11'h96;
    en = en | bit_of(2) | bit_of(150);
    expect_msi(2); expect_msi(150);
    raise(bit_of(2) | bit_of(150));
    wait_drain(50, 1'b0);

    // Domain IE low blocks selection
    ie = 1'b0;
    hart_tab[60] = 3'd3; eiid_tab[60] = 11'h60;
    en = en | bit_of(60);
    raise(bit_of(60));
    repeat (5) begin
      @(negedge clk);
      check("t7_ie_busy", busy, 1'b0);
      check("t7_ie_valid", msi_valid, 1'b0);
    end
    expect_msi(60);
    tick();
    ie = 1'b1;
    wait_drain(50, 1'b0);

    // Random single-source traffic with random ready, wrapping bases, hart >= 5
    en = '1;
    for (int it = 0; it < 20; it++) begin
      idx = $urandom_range(1, NR_SRC - 1);
      hart_tab[idx] = 3'($urandom_range(0, 7));
      eiid_tab[idx] = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      base = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_F000
                                         : ({32'($urandom), 32'($urandom)} & ~64'hfff);
      if (eiid_tab[idx] == 11'd0) expect_clr_only(idx);
      else expect_msi(idx);
      raise(bit_of(idx));
      wait_drain(200, 1'b1);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
